// File: rtl/md_issue_ctrl.sv
// Issue controller for the E-stage multiply/divide unit: gates Start, mirrors the
// unit's busy window with a local countdown, stalls D and keeps saturating perf counters.
module md_issue_ctrl #(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             Req,
  input  logic             D_MDClass,
  input  logic             E_Start,
  input  logic [2:0]       E_MDOp,
  input  logic             MD_Busy,
  output logic             Start,
  output logic [2:0]       MDOp,
  output logic             Stall,
  output logic             BusyMirror,
  output logic [3:0]       Cnt,
  output logic             Mismatch,
  output logic [CNT_W-1:0] MulCnt,
  output logic [CNT_W-1:0] DivCnt,
  output logic [CNT_W-1:0] StallCnt
);

  // Start is a one-cycle strobe with no ready: the unit can take an op whenever
  // BusyMirror is 0, and Busy rises on the cycle after Start.
  localparam logic [2:0] MD_DIV  = 3'b010;
  localparam logic [2:0] MD_DIVU = 3'b011;
  localparam logic [3:0] MUL_LAT_C = 4'(MUL_LAT);
  localparam logic [3:0] DIV_LAT_C = 4'(DIV_LAT);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic             mismatch_q, mismatch_d;
  logic [CNT_W-1:0] mul_cnt_q, mul_cnt_d;
  logic [CNT_W-1:0] div_cnt_q, div_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic idle, accept, is_div, violation, busy_diff;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + {{(CNT_W-1){1'b0}}, 1'b1};
  endfunction

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_cnt_d   = mul_cnt_q;
    div_cnt_d   = div_cnt_q;
    stall_cnt_d = stall_cnt_q;

    idle      = (state_q == S_IDLE);
    accept    = reset & idle & E_Start & ~Req;
    is_div    = (E_MDOp == MD_DIV) | (E_MDOp == MD_DIVU);
    violation = ~idle & E_Start;
    busy_diff = (MD_Busy != ~idle);

    Start      = accept;
    MDOp       = E_MDOp;
    Stall      = reset & D_MDClass & (~idle | E_Start);
    BusyMirror = ~idle;
    Cnt        = cnt_q;
    MulCnt     = mul_cnt_q;
    DivCnt     = div_cnt_q;
    StallCnt   = stall_cnt_q;

    // An E_Start arriving mid-window is dropped; it only raises the error flag.
    mismatch_d = mismatch_q | busy_diff | violation;
    Mismatch   = reset & mismatch_d;

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (is_div) begin
            state_d   = S_DIV;
            cnt_d     = DIV_LAT_C;
            div_cnt_d = sat_inc(div_cnt_q);
          end else begin
            state_d   = S_MUL;
            cnt_d     = MUL_LAT_C;
            mul_cnt_d = sat_inc(mul_cnt_q);
          end
        end
      end
      S_MUL, S_DIV: begin
        if (cnt_q == 4'd1) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = 4'd0;
      end
    endcase

    if (Stall) stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= 4'd0;
      mismatch_q  <= 1'b0;
      mul_cnt_q   <= '0;
      div_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      mismatch_q  <= mismatch_d;
      mul_cnt_q   <= mul_cnt_d;
      div_cnt_q   <= div_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

endmodule
